// File: rtl/run_detector.sv
// Multi-channel run-length detector: per-channel count of consecutive sampled 1s, flagged at threshold N.
// Optional macro RUN_DET_RETRIGGER_EN: hit re-pulses at every multiple of N within a run.
module run_detector #(
    parameter int unsigned CH = 4,
    parameter int unsigned N  = 3,
    parameter int unsigned CW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CH-1:0]    a,
    input  logic [CH-1:0]    clr,
    output logic [CH-1:0]    q,
    output logic [CH-1:0]    hit,
    output logic [CH*CW-1:0] run_len,
    output logic             any_q
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    // Threshold must be reachable without the counter saturating first.
    if (N == 0 || N > 32'(CNT_MAX)) begin : g_bad_param
        $error("run_detector: illegal N=%0d for CW=%0d", N, CW);
    end

    logic [CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [CH-1:0]         hit_q, hit_d;
    logic [CH-1:0]         q_q, q_d;
    logic                  any_q_q, any_q_d;

`ifdef RUN_DET_RETRIGGER_EN
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    logic [CH-1:0][PW-1:0] ph_q, ph_d;
`endif

    // Per-channel next state: clr beats en, en=0 holds the run.
    always_comb begin
        cnt_d = cnt_q;
        hit_d = '0;
        q_d   = '0;
`ifdef RUN_DET_RETRIGGER_EN
        ph_d  = ph_q;
`endif
        for (int i = 0; i < int'(CH); i++) begin
            if (clr[i]) begin
                cnt_d[i] = '0;
`ifdef RUN_DET_RETRIGGER_EN
                ph_d[i]  = '0;
`endif
            end else if (en) begin
                if (a[i]) begin
                    cnt_d[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CW'(1);
`ifdef RUN_DET_RETRIGGER_EN
                    hit_d[i] = (ph_q[i] == PW'(N - 1));
                    ph_d[i]  = hit_d[i] ? '0 : ph_q[i] + PW'(1);
`else
                    hit_d[i] = (cnt_q[i] == CW'(N - 1));
`endif
                end else begin
                    cnt_d[i] = '0;
`ifdef RUN_DET_RETRIGGER_EN
                    ph_d[i]  = '0;
`endif
                end
            end
            q_d[i] = (cnt_d[i] >= CW'(N));
        end
        any_q_d = |q_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            hit_q   <= '0;
            q_q     <= '0;
            any_q_q <= 1'b0;
`ifdef RUN_DET_RETRIGGER_EN
            ph_q    <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            q_q     <= q_d;
            any_q_q <= any_q_d;
`ifdef RUN_DET_RETRIGGER_EN
            ph_q    <= ph_d;
`endif
        end
    end

    assign q       = q_q;
    assign hit     = hit_q;
    assign run_len = cnt_q;
    assign any_q   = any_q_q;

endmodule

// File: tb/tb_run_detector.sv
// Directed self-checking bench for run_detector with CH=2, N=3, CW=4.
module tb_run_detector;

    localparam int unsigned CH = 2;
    localparam int unsigned N  = 3;
    localparam int unsigned CW = 4;

    logic             clk;
    logic             reset;
    logic             en;
    logic [CH-1:0]    a;
    logic [CH-1:0]    clr;
    logic [CH-1:0]    q;
    logic [CH-1:0]    hit;
    logic [CH*CW-1:0] run_len;
    logic             any_q;

    int vectors = 0;
    int errs    = 0;

    run_detector #(.CH(CH), .N(N), .CW(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .a       (a),
        .clr     (clr),
        .q       (q),
        .hit     (hit),
        .run_len (run_len),
        .any_q   (any_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] brk_a   [6];
    logic [3:0] brk_len [6];
    logic       en_seq  [5];
    logic [3:0] gap_len [5];
    logic       rt_hit  [10];

    initial begin
        brk_a   = '{1, 1, 0, 1, 1, 1};
        brk_len = '{1, 2, 0, 1, 2, 3};
        en_seq  = '{1, 0, 1, 0, 1};
        gap_len = '{1, 1, 2, 2, 3};
        for (int k = 0; k < 10; k++) begin
`ifdef RUN_DET_RETRIGGER_EN
            rt_hit[k] = ((k + 1) % 3 == 0);
`else
            rt_hit[k] = (k == 2);
`endif
        end

        // Reset held with active inputs
        reset = 1'b0; en = 1'b1; a = 2'b11; clr = 2'b00;
        tick(); tick();
        check("rst_q", 32'(q), 32'h0);
        check("rst_hit", 32'(hit), 32'h0);
        check("rst_len", 32'(run_len), 32'h0);
        check("rst_any", 32'(any_q), 32'h0);

        reset = 1'b1;
        tick(); tick();
        check("first_q_early", 32'(q), 32'h0);
        tick();
        check("first_q", 32'(q), 32'h3);
        check("first_hit", 32'(hit), 32'h3);
        check("first_len", 32'(run_len), 32'h33);
        check("first_any", 32'(any_q), 32'h1);
        tick();
        check("first_hit_gone", 32'(hit), 32'h0);
        check("first_len4", 32'(run_len), 32'h44);

        // Reset mid-run
        reset = 1'b0;
        tick();
        check("midrst_len", 32'(run_len), 32'h0);
        check("midrst_q", 32'(q), 32'h0);
        reset = 1'b1; a = 2'b00;
        tick();

        // Run broken on ch0
        for (int k = 0; k < 6; k++) begin
            a = {1'b0, brk_a[k][0]};
            tick();
            check($sformatf("brk_len%0d", k), 32'(run_len[3:0]), 32'(brk_len[k]));
            check($sformatf("brk_q%0d", k), 32'(q[0]), (k == 5) ? 32'h1 : 32'h0);
            check($sformatf("brk_hit%0d", k), 32'(hit[0]), (k == 5) ? 32'h1 : 32'h0);
        end
        a = 2'b00;
        tick();
        check("brk_fall", 32'(q[0]), 32'h0);

        // Enable gaps are transparent
        a = 2'b01;
        for (int k = 0; k < 5; k++) begin
            en = en_seq[k];
            tick();
            check($sformatf("gap_len%0d", k), 32'(run_len[3:0]), 32'(gap_len[k]));
            check($sformatf("gap_hit%0d", k), 32'(hit[0]), (k == 4) ? 32'h1 : 32'h0);
            check($sformatf("gap_q%0d", k), 32'(q[0]), (k == 4) ? 32'h1 : 32'h0);
        end
        en = 1'b0;
        tick();
        check("gap_idle_hit", 32'(hit[0]), 32'h0);
        check("gap_idle_q", 32'(q[0]), 32'h1);
        en = 1'b1; a = 2'b00;
        tick();

        // Saturation, then clear on ch1 only
        a = 2'b11;
        for (int k = 0; k < 20; k++) tick();
        check("sat_len1", 32'(run_len[7:4]), 32'hF);
        check("sat_len0", 32'(run_len[3:0]), 32'hF);
        check("sat_q", 32'(q), 32'h3);
        check("sat_hit", 32'(hit), 32'h0);
        clr = 2'b10;
        tick();
        check("clr_len", 32'(run_len), 32'h0F);
        check("clr_q", 32'(q), 32'h1);
        check("clr_hit", 32'(hit), 32'h0);
        check("clr_any", 32'(any_q), 32'h1);
        clr = 2'b00; a = 2'b00;
        tick();
        check("clr_all_any", 32'(any_q), 32'h0);

        // Retrigger behaviour over a 10-long run
        a = 2'b01;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("rt_hit%0d", k + 1), 32'(hit[0]), 32'(rt_hit[k]));
        end
        check("rt_len", 32'(run_len[3:0]), 32'd10);
        a = 2'b00;
        tick();

        // Channel independence
        a = 2'b01;
        tick(); tick(); tick();
        check("ind_q", 32'(q), 32'h1);
        check("ind_any", 32'(any_q), 32'h1);
        check("ind_len1", 32'(run_len[7:4]), 32'h0);
        check("ind_hit", 32'(hit), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
